// File: rtl/freq_capture_if.sv
// Measurement request/result bundle between a controller and freq_capture,
// including the handshake toward the serial transmitter.
interface freq_capture_if;
  // Handshakes: meas_start is accepted only on a cycle where busy=0, and busy
  // rises on the next cycle. ser_start stays high until ser_busy=1 is sampled,
  // then drops. Results hold steady from that request until the next accept.
  logic         meas_start;
  logic [1:0]   mode;
  logic         busy;
  logic [31:0]  f_edges;
  logic [31:0]  f_clks;
  logic [319:0] t_val;
  logic         timeout;
  logic         ser_start;
  logic         ser_busy;
  logic [1:0]   ser_mode;

  modport master (
    output meas_start, mode, ser_busy,
    input  busy, f_edges, f_clks, t_val, timeout, ser_start, ser_mode
  );

  modport slave (
    input  meas_start, mode, ser_busy,
    output busy, f_edges, f_clks, t_val, timeout, ser_start, ser_mode
  );
endinterface

// File: rtl/freq_capture.sv
// Gated frequency count plus ten-period capture of sig_in, handed to a serial
// transmitter. Define FREQ_CAPTURE_TIMEOUT_EN to abort on a stalled sig_in.
module freq_capture #(
  parameter int GATE_CYCLES    = 50_000_000,
  parameter int TIMEOUT_CYCLES = 100_000_000
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           sig_in,
  freq_capture_if.slave  bus,
  output logic [2:0]     dbg_state
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    F_ARM    = 3'd1,
    F_GATE   = 3'd2,
    T_ARM    = 3'd3,
    T_CAP    = 3'd4,
    HANDOFF  = 3'd5,
    SER_WAIT = 3'd6
  } state_t;

  localparam logic [31:0] GATE_C = 32'(GATE_CYCLES);

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  state_t       state_q, state_d;
  logic         sync1_q, sync1_d, sync2_q, sync2_d, sync3_q, sync3_d;
  logic         edge_q, edge_d;
  logic [1:0]   ser_mode_q, ser_mode_d;
  logic [31:0]  f_edges_q, f_edges_d;
  logic [31:0]  f_clks_q, f_clks_d;
  logic [319:0] t_val_q, t_val_d;
  logic [31:0]  t_cnt_q, t_cnt_d;
  logic [3:0]   idx_q, idx_d;
  logic         ser_start_q, ser_start_d;
  logic         busy_q, busy_d;
  logic [31:0]  f_clks_inc;
`ifdef FREQ_CAPTURE_TIMEOUT_EN
  localparam logic [31:0] TIMEOUT_C = 32'(TIMEOUT_CYCLES);
  logic         timeout_q, timeout_d;
  logic [31:0]  idle_q, idle_d;
  logic         idle_hit;
`endif

  assign f_clks_inc = sat_inc(f_clks_q);

  always_comb begin
    state_d     = state_q;
    sync1_d     = sig_in;
    sync2_d     = sync1_q;
    sync3_d     = sync2_q;
    edge_d      = sync2_q & ~sync3_q;
    ser_mode_d  = ser_mode_q;
    f_edges_d   = f_edges_q;
    f_clks_d    = f_clks_q;
    t_val_d     = t_val_q;
    t_cnt_d     = t_cnt_q;
    idx_d       = idx_q;
    ser_start_d = ser_start_q;
`ifdef FREQ_CAPTURE_TIMEOUT_EN
    timeout_d   = timeout_q;
    idle_d      = idle_q;
    idle_hit    = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        if (bus.meas_start) begin
          ser_mode_d = bus.mode;
          f_edges_d  = '0;
          f_clks_d   = '0;
          t_val_d    = '0;
`ifdef FREQ_CAPTURE_TIMEOUT_EN
          timeout_d  = 1'b0;
`endif
          if (bus.mode[1])      state_d = F_ARM;
          else if (bus.mode[0]) state_d = T_ARM;
          else begin
            state_d     = HANDOFF;
            ser_start_d = 1'b1;
          end
        end
      end
      F_ARM: begin
        if (edge_q) begin
          f_clks_d  = '0;
          f_edges_d = '0;
          state_d   = F_GATE;
        end
      end
      F_GATE: begin
        f_clks_d = f_clks_inc;
        // The closing edge is counted, so the window spans whole sig_in periods.
        if (edge_q) begin
          f_edges_d = sat_inc(f_edges_q);
          if (f_clks_inc >= GATE_C) begin
            if (ser_mode_q[0]) state_d = T_ARM;
            else begin
              state_d     = HANDOFF;
              ser_start_d = 1'b1;
            end
          end
        end
      end
      T_ARM: begin
        if (edge_q) begin
          t_cnt_d = 32'd1;
          idx_d   = 4'd1;
          state_d = T_CAP;
        end
      end
      T_CAP: begin
        if (edge_q) begin
          for (int k = 0; k < 10; k++) begin
            if (idx_q == 4'(k + 1)) t_val_d[32*k +: 32] = t_cnt_q;
          end
          t_cnt_d = 32'd1;
          idx_d   = idx_q + 4'd1;
          if (idx_q == 4'd10) begin
            state_d     = HANDOFF;
            ser_start_d = 1'b1;
          end
        end else begin
          t_cnt_d = sat_inc(t_cnt_q);
        end
      end
      HANDOFF: begin
        if (bus.ser_busy) begin
          ser_start_d = 1'b0;
          state_d     = SER_WAIT;
        end
      end
      SER_WAIT: begin
        if (!bus.ser_busy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

`ifdef FREQ_CAPTURE_TIMEOUT_EN
    // An edge always wins over expiry, so expiry never collides with a slot store.
    if (state_q inside {F_ARM, F_GATE, T_ARM, T_CAP}) begin
      if (edge_q) idle_d = '0;
      else if (idle_q + 32'd1 >= TIMEOUT_C) idle_hit = 1'b1;
      else idle_d = idle_q + 32'd1;
    end
    if (idle_hit) begin
      timeout_d   = 1'b1;
      state_d     = HANDOFF;
      ser_start_d = 1'b1;
      if (state_q inside {F_ARM, F_GATE}) begin
        f_edges_d = '0;
        f_clks_d  = '0;
      end else begin
        t_val_d = '0;
      end
    end
    if (state_d != state_q) idle_d = '0;
`endif

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      sync3_q     <= 1'b0;
      edge_q      <= 1'b0;
      ser_mode_q  <= 2'b00;
      f_edges_q   <= '0;
      f_clks_q    <= '0;
      t_val_q     <= '0;
      t_cnt_q     <= '0;
      idx_q       <= '0;
      ser_start_q <= 1'b0;
      busy_q      <= 1'b0;
`ifdef FREQ_CAPTURE_TIMEOUT_EN
      timeout_q   <= 1'b0;
      idle_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      sync3_q     <= sync3_d;
      edge_q      <= edge_d;
      ser_mode_q  <= ser_mode_d;
      f_edges_q   <= f_edges_d;
      f_clks_q    <= f_clks_d;
      t_val_q     <= t_val_d;
      t_cnt_q     <= t_cnt_d;
      idx_q       <= idx_d;
      ser_start_q <= ser_start_d;
      busy_q      <= busy_d;
`ifdef FREQ_CAPTURE_TIMEOUT_EN
      timeout_q   <= timeout_d;
      idle_q      <= idle_d;
`endif
    end
  end

  assign bus.busy      = busy_q;
  assign bus.f_edges   = f_edges_q;
  assign bus.f_clks    = f_clks_q;
  assign bus.t_val     = t_val_q;
  assign bus.ser_start = ser_start_q;
  assign bus.ser_mode  = ser_mode_q;
`ifdef FREQ_CAPTURE_TIMEOUT_EN
  assign bus.timeout   = timeout_q;
`else
  assign bus.timeout   = 1'b0;
`endif
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_freq_capture.sv
// Directed bench for freq_capture with GATE_CYCLES=100, TIMEOUT_CYCLES=500;
// sig_in comes from a programmable two-period pulse generator.
module tb_freq_capture;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_F_GATE   = 3'd2;
  localparam logic [2:0] ST_T_ARM    = 3'd3;
  localparam logic [2:0] ST_HANDOFF  = 3'd5;
  localparam logic [2:0] ST_SER_WAIT = 3'd6;

  logic       clk;
  logic       rst_n;
  logic       sig_in;
  logic [2:0] dbg_state;
  int         checks = 0;
  int         errors = 0;

  logic gen_on = 1'b0;
  int   per_a  = 10;
  int   per_b  = 10;

  freq_capture_if bus ();

  freq_capture #(.GATE_CYCLES(100), .TIMEOUT_CYCLES(500)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sig_in    (sig_in),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  // sig_in generator: rises at phase 0, high two cycles, periods alternate a/b.
  initial begin
    int ph;
    int cur;
    logic first;
    ph = 0; cur = 10; first = 1'b1;
    sig_in = 1'b0;
    forever begin
      @(negedge clk);
      if (!gen_on) begin
        sig_in = 1'b0;
        ph = 0;
        first = 1'b1;
      end else begin
        if (first) begin
          cur = per_a;
          first = 1'b0;
        end
        sig_in = (ph < 2);
        ph++;
        if (ph >= cur) begin
          ph = 0;
          cur = (cur == per_a) ? per_b : per_a;
        end
      end
    end
  end

  // Driver tasks
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [319:0] obs, input logic [319:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start_meas(input logic [1:0] m);
    bus.mode = m;
    bus.meas_start = 1'b1;
    tick(1);
    bus.meas_start = 1'b0;
  endtask

  task automatic set_gen(input logic on, input int a, input int b);
    per_a = a;
    per_b = b;
    gen_on = on;
  endtask

  task automatic do_handoff(input string tag);
    int k;
    k = 0;
    while (!bus.ser_start && k < 3000) begin
      tick(1);
      k++;
    end
    chk({tag, "_ser_start_seen"}, bus.ser_start, 1'b1);
    tick(3);
    chk({tag, "_ser_start_held"}, bus.ser_start, 1'b1);
    chk({tag, "_state_handoff"}, dbg_state, ST_HANDOFF);
    bus.ser_busy = 1'b1;
    tick(1);
    chk({tag, "_ser_start_drop"}, bus.ser_start, 1'b0);
    chk({tag, "_state_ser_wait"}, dbg_state, ST_SER_WAIT);
    tick(2);
    bus.ser_busy = 1'b0;
    tick(1);
    chk({tag, "_idle_busy"}, bus.busy, 1'b0);
    chk({tag, "_idle_state"}, dbg_state, ST_IDLE);
  endtask

  // Directed sequence with hand-computed expectations
  initial begin
    logic [319:0] exp_t;
    int k;
    int seen;
    rst_n = 1'b0;
    bus.meas_start = 1'b0;
    bus.mode = 2'b00;
    bus.ser_busy = 1'b0;
    tick(3);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_ser_start", bus.ser_start, 1'b0);
    chk("rst_f_edges", bus.f_edges, 32'd0);
    chk("rst_f_clks", bus.f_clks, 32'd0);
    chk("rst_t_val", bus.t_val, 320'd0);
    chk("rst_ser_mode", bus.ser_mode, 2'b00);
    chk("rst_timeout", bus.timeout, 1'b0);
    rst_n = 1'b1;
    tick(3);
    chk("rst_state", dbg_state, ST_IDLE);

    // Gate only, period 10
    set_gen(1'b1, 10, 10);
    start_meas(2'b10);
    chk("a_busy", bus.busy, 1'b1);
    chk("a_ser_mode", bus.ser_mode, 2'b10);
    do_handoff("a");
    chk("a_f_edges", bus.f_edges, 32'd10);
    chk("a_f_clks", bus.f_clks, 32'd100);
    chk("a_t_val", bus.t_val, 320'd0);
    tick(20);
    chk("a_single_ser_start", bus.ser_start, 1'b0);
    set_gen(1'b0, 10, 10);
    tick(10);

    // Gate then periods, period 7
    set_gen(1'b1, 7, 7);
    start_meas(2'b11);
    do_handoff("b");
    exp_t = '0;
    for (int i = 0; i < 10; i++) exp_t[32*i +: 32] = 32'd7;
    chk("b_f_edges", bus.f_edges, 32'd15);
    chk("b_f_clks", bus.f_clks, 32'd105);
    chk("b_t_val", bus.t_val, exp_t);
    chk("b_ser_mode", bus.ser_mode, 2'b11);
    set_gen(1'b0, 7, 7);
    tick(10);

    // Periods only, alternating 5/9
    set_gen(1'b1, 5, 9);
    start_meas(2'b01);
    do_handoff("c");
    exp_t = '0;
    for (int i = 0; i < 10; i++) exp_t[32*i +: 32] = (i % 2 == 0) ? 32'd5 : 32'd9;
    chk("c_t_val", bus.t_val, exp_t);
    chk("c_f_edges", bus.f_edges, 32'd0);
    chk("c_f_clks", bus.f_clks, 32'd0);
    set_gen(1'b0, 5, 9);
    tick(10);

    // meas_start during F_GATE is ignored
    set_gen(1'b1, 10, 10);
    start_meas(2'b10);
    tick(60);
    chk("d_in_gate", dbg_state, ST_F_GATE);
    start_meas(2'b01);
    chk("d_ignored_mode", bus.ser_mode, 2'b10);
    chk("d_still_gate", dbg_state, ST_F_GATE);
    do_handoff("d");
    chk("d_f_edges", bus.f_edges, 32'd10);
    chk("d_f_clks", bus.f_clks, 32'd100);
    chk("d_t_val", bus.t_val, 320'd0);
    set_gen(1'b0, 10, 10);
    tick(10);

    // mode 00 goes straight to HANDOFF with zero results
    start_meas(2'b00);
    chk("e_state", dbg_state, ST_HANDOFF);
    chk("e_ser_start", bus.ser_start, 1'b1);
    chk("e_f_edges", bus.f_edges, 32'd0);
    chk("e_f_clks", bus.f_clks, 32'd0);
    chk("e_t_val", bus.t_val, 320'd0);
    do_handoff("e");
    tick(5);

    // sig_in held low
    start_meas(2'b01);
`ifdef FREQ_CAPTURE_TIMEOUT_EN
    k = 0;
    while (!bus.ser_start && k < 700) begin
      tick(1);
      k++;
    end
    chk("f_timeout_latency", ((k + 1) >= 495 && (k + 1) <= 505), 1'b1);
    do_handoff("f");
    chk("f_timeout", bus.timeout, 1'b1);
    chk("f_t_val", bus.t_val, 320'd0);
`else
    tick(700);
    chk("f_busy_stuck", bus.busy, 1'b1);
    chk("f_state_t_arm", dbg_state, ST_T_ARM);
    chk("f_no_ser_start", bus.ser_start, 1'b0);
    chk("f_timeout_tied", bus.timeout, 1'b0);
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(2);
`endif

    // Reset during T_CAP slot 4
    set_gen(1'b1, 10, 10);
    start_meas(2'b01);
    k = 0;
    while (bus.t_val[95:64] == 32'd0 && k < 500) begin
      tick(1);
      k++;
    end
    chk("g_slot3", bus.t_val[95:64], 32'd10);
    tick(2);
    rst_n = 1'b0;
    #1;
    chk("g_rst_busy", bus.busy, 1'b0);
    chk("g_rst_t_val", bus.t_val, 320'd0);
    chk("g_rst_ser_start", bus.ser_start, 1'b0);
    chk("g_rst_ser_mode", bus.ser_mode, 2'b00);
    chk("g_rst_state", dbg_state, ST_IDLE);
    tick(2);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 300; i++) begin
      tick(1);
      if (bus.ser_start) seen++;
    end
    chk("g_no_ser_start_after_reset", seen, 0);
    chk("g_idle_after_reset", bus.busy, 1'b0);
    set_gen(1'b0, 10, 10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/freq_capture.md
FREQ_CAPTURE -- requirements
Module: freq_capture

Interface
REQ-001 SHALL have parameter GATE_CYCLES, default 50_000_000, minimum gate length in clk cycles (1 s at 50 MHz).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 100_000_000, number of clk cycles with no sig_in edge before abort.
REQ-003 clk  input  1  system clock; all logic on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 sig_in  input  1  measured signal, asynchronous to clk.
REQ-006 meas_start  input  1  one-cycle-or-longer request to start a measurement; sampled only in IDLE.
REQ-007 mode  input  2  bit1 = run frequency gate, bit0 = run period capture; latched on accept.
REQ-008 busy  output  1  high in every state except IDLE.
REQ-009 f_edges  output  32  rising edges counted in the gate window.
REQ-010 f_clks  output  32  clk cycles in the gate window.
REQ-011 t_val  output  320  ten 32-bit periods in clk cycles; slot k (1..10) at bits [32k-1:32k-32].
REQ-012 timeout  output  1  sticky flag; set by the last measurement if it aborted.
REQ-013 ser_start  output  1  start request to the serial transmitter.
REQ-014 ser_busy  input  1  busy from the serial transmitter.
REQ-015 ser_mode  output  2  latched mode presented to the serial transmitter.

Function
REQ-016 SHALL pass sig_in through a 2-FF synchroniser followed by a registered rising-edge detect; every edge then sees the same fixed 3-cycle delay, so measured intervals are exact.
REQ-017 SHALL use states IDLE, F_ARM, F_GATE, T_ARM, T_CAP, HANDOFF and SER_WAIT.
REQ-018 IDLE with meas_start=1 SHALL latch mode into ser_mode and clear f_edges, f_clks, t_val and timeout.
REQ-019 Next state from IDLE: F_ARM if mode[1]=1; otherwise T_ARM if mode[0]=1; otherwise HANDOFF.
REQ-020 F_ARM SHALL wait for an edge; that edge opens the gate with f_clks=0 and f_edges=0, then go to F_GATE.
REQ-021 F_GATE SHALL increment f_clks every cycle and f_edges on each edge.
REQ-022 F_GATE SHALL close on the first edge for which f_clks+1 >= GATE_CYCLES; that edge is counted, giving an integer number of sig_in periods.
REQ-023 On gate close, SHALL go to T_ARM if mode[0]=1, else HANDOFF.
REQ-024 T_ARM SHALL wait for an edge, then go to T_CAP with the period counter at 1 and slot index at 1.
REQ-025 In T_CAP, on each edge SHALL store the counter into slot index, reset the counter to 1 and increment the index; after slot 10 is stored, SHALL go to HANDOFF.
REQ-026 All counters SHALL saturate at 32'hFFFF_FFFF and never wrap.
REQ-027 HANDOFF SHALL hold ser_start=1 until ser_busy=1 is sampled, then drop ser_start and go to SER_WAIT.
REQ-028 SER_WAIT SHALL return to IDLE on the first cycle ser_busy=0; the outputs stay stable from HANDOFF until the next accept.
REQ-029 meas_start SHALL be ignored while busy=1.
REQ-030 An edge in the same cycle as a state entry SHALL be evaluated by the entered state on the following cycle only; it is never double-counted.

Reset
REQ-031 On rst_n=0, SHALL immediately force state to IDLE, clear busy, ser_start, timeout, f_edges, f_clks and t_val, set ser_mode=0, and clear the synchroniser and edge detect.
REQ-032 Reset mid-measurement or mid-handoff SHALL discard all partial results; no ser_start SHALL follow reset without a new meas_start.

Configuration
REQ-033 With macro FREQ_CAPTURE_TIMEOUT_EN defined: an idle counter, cleared on every edge and on state entry, runs in F_ARM, F_GATE, T_ARM and T_CAP.
REQ-034 When that idle counter reaches TIMEOUT_CYCLES, SHALL set timeout=1, zero the incomplete results and go to HANDOFF.
REQ-035 Without the macro, SHALL build no timeout logic, tie timeout to 0, and wait for edges indefinitely.

Verification (GATE_CYCLES=100, TIMEOUT_CYCLES=500)
REQ-036 sig_in period 10 clk, mode=2'b10 -> f_edges=10, f_clks=100, t_val all 0, one ser_start pulse held until ser_busy.
REQ-037 sig_in period 7 clk, mode=2'b11 -> f_edges=15, f_clks=105, every t_val slot=7, ser_mode=2'b11.
REQ-038 sig_in alternating periods 5/9, mode=2'b01 -> slots 1..10 = 5,9,5,9,...; f_edges=f_clks=0.
REQ-039 sig_in held low, mode=2'b01, macro on -> timeout=1 about 500 cycles after accept, all slots 0; macro off -> busy stays 1.
REQ-040 rst_n pulsed low during T_CAP slot 4 -> all outputs 0 in the same cycle, busy=0, no ser_start afterwards.
REQ-041 meas_start pulsed during F_GATE, and mode=2'b00 from IDLE -> the first is ignored; the second goes straight to HANDOFF with zero results.
